// File: rtl/mem_pkg.sv
// mem_pkg: shared response types and byte-address decoding for pipelined_memory.
package mem_pkg;

    localparam int LATENCY_MAX = 4;
    localparam int DATA_W_MAX  = 32;

    typedef struct packed {
        logic [DATA_W_MAX-1:0] data;
        logic                  err;
    } mem_resp_t;

    typedef struct packed {
        logic [31:0] index;
        logic        err;
    } mem_chk_t;

    // Turns a byte address into a word index; flags misaligned or out-of-range
    // addresses. High address bits are never dropped, so nothing wraps around.
    function automatic mem_chk_t mem_addr_check(
        input logic [31:0] addr,
        input int unsigned bytes_log2,
        input int unsigned depth
    );
        mem_chk_t    chk;
        logic [31:0] low_mask;
        low_mask  = (32'd1 << bytes_log2) - 32'd1;
        chk.index = addr >> bytes_log2;
        chk.err   = ((addr & low_mask) != 32'd0) || (chk.index >= depth);
        return chk;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: synchronous FIFO with one push and one pop per cycle.
// Pointers carry an extra wrap bit so full and empty can be told apart.
module resp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] store [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr[PW-1:0]];

    // Read and write pointers advance independently; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Payload storage needs no reset; the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pipelined_memory.sv
// pipelined_memory: word memory with a fully pipelined valid/ready request
// channel, byte-masked read-before-write, and in-order responses through a
// credit-protected response FIFO.
module pipelined_memory
    import mem_pkg::*;
#(
    parameter int    DATA_W     = 32,
    parameter int    DEPTH      = 1024,
    parameter int    LATENCY    = 2,
    parameter int    RESP_DEPTH = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [31:0]         req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [DATA_W-1:0]   resp_data_o,
    output logic                resp_err_o
);

    localparam int BYTES      = DATA_W / 8;
    localparam int BYTES_LOG2 = $clog2(BYTES);
    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = $clog2(RESP_DEPTH + 1);

    if (DATA_W % 8 != 0 || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("pipelined_memory: DATA_W must be a multiple of 8 and at most DATA_W_MAX");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pipelined_memory: DEPTH must be a power of 2");
    end
    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("pipelined_memory: LATENCY out of range");
    end
    if ((RESP_DEPTH & (RESP_DEPTH - 1)) != 0 || RESP_DEPTH < LATENCY + 1) begin : g_bad_resp_depth
        $error("pipelined_memory: RESP_DEPTH must be a power of 2 and at least LATENCY+1");
    end

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    mem_chk_t          chk;
    mem_resp_t         rd_resp;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] new_word;
    logic              accept;
    logic              pop;
    logic [CW-1:0]     outst;
    logic              push_valid;
    mem_resp_t         push_resp;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;

    assign req_ready_o = (outst < CW'(RESP_DEPTH)) && !rst;
    assign accept      = req_valid_i && req_ready_o;

    // Decode the address, sample the old word and build the byte-merged new word.
    always_comb begin
        chk      = mem_addr_check(req_addr_i, BYTES_LOG2, DEPTH);
        old_word = mem[chk.index[AW-1:0]];
        rd_resp  = '0;
        rd_resp.err = chk.err;
        if (!chk.err) rd_resp.data[DATA_W-1:0] = old_word;
        new_word = old_word;
        for (int b = 0; b < BYTES; b++) begin
            if (req_be_i[b]) new_word[8*b +: 8] = req_wdata_i[8*b +: 8];
        end
    end

    // Writes commit at the accept edge, so a read in the next cycle sees them.
    always_ff @(posedge clk) begin
        if (accept && req_we_i && !chk.err) mem[chk.index[AW-1:0]] <= new_word;
    end

    if (LATENCY == 1) begin : g_direct
        assign push_valid = accept;
        assign push_resp  = rd_resp;
    end else begin : g_pipe
        logic      stage_valid [LATENCY-1];
        mem_resp_t stage_resp  [LATENCY-1];

        // Valid tags travel with each response and are wiped by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < LATENCY-1; k++) stage_valid[k] <= 1'b0;
            end else begin
                stage_valid[0] <= accept;
                for (int k = 1; k < LATENCY-1; k++) stage_valid[k] <= stage_valid[k-1];
            end
        end

        // Response payload shift register, qualified by the valid tags.
        always_ff @(posedge clk) begin
            stage_resp[0] <= rd_resp;
            for (int k = 1; k < LATENCY-1; k++) stage_resp[k] <= stage_resp[k-1];
        end

        assign push_valid = stage_valid[LATENCY-2];
        assign push_resp  = stage_resp[LATENCY-2];
    end

    resp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_valid),
        .push_data ({push_resp.data[DATA_W-1:0], push_resp.err}),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign resp_valid_o = !fifo_empty && !rst;
    assign resp_data_o  = rst ? '0 : fifo_head[DATA_W:1];
    assign resp_err_o   = rst ? 1'b0 : fifo_head[0];
    assign pop          = resp_valid_o && resp_ready_i;

    // Credit counter: one credit per accepted request, returned on response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst <= '0;
        end else if (accept && !pop) begin
            outst <= outst + CW'(1);
        end else if (!accept && pop) begin
            outst <= outst - CW'(1);
        end
    end

endmodule
